imem_loader: RTL and testbench

- Writer side of the instruction memory: receives a little-endian byte stream (e.g. from a UART receiver), packs it into 32-bit instruction words, and issues one-cycle word writes to the imem write port.
- Writes start at byte address 0 and increment by 4.
- Holds the core in reset while a load is in progress, so the CPU only fetches once the program image is complete.

---
 rtl/imem_loader.sv | 157 +++++++++++++++
 tb/tb_imem_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them to imem.
// Define IMEM_LOADER_CSUM_EN to add a running checksum output (csum).
module imem_loader #(
    parameter int ADDR_W    = 15,
    parameter int MAX_WORDS = 32768
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              cpu_rst_hold,
`ifdef IMEM_LOADER_CSUM_EN
    output logic [31:0]       csum,
`endif
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        WRITE,
        DONE
    } state_t;

    localparam logic [ADDR_W:0] MAX_L = (ADDR_W+1)'(MAX_WORDS);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       shift_q, shift_d;
    logic              byte_ready_q, byte_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W:0]   len_clamped;
`ifdef IMEM_LOADER_CSUM_EN
    logic [31:0]       csum_q, csum_d;
`endif

    assign len_clamped = (len_words > MAX_L) ? MAX_L : len_words;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_count_d = word_count_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
`ifdef IMEM_LOADER_CSUM_EN
        csum_d       = csum_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    len_d        = len_clamped;
                    word_count_d = '0;
                    word_idx_d   = '0;
                    byte_idx_d   = '0;
                    shift_d      = '0;
`ifdef IMEM_LOADER_CSUM_EN
                    csum_d       = '0;
`endif
                    state_d      = (len_clamped == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (byte_valid && byte_ready_q) begin
                    shift_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    // Word is complete: present it on the write port next cycle
                    if (byte_idx_q == 2'd3) begin
                        state_d     = WRITE;
                        mem_addr_d  = {{(30-ADDR_W){1'b0}}, word_idx_q, 2'b00};
                        mem_wdata_d = shift_d;
                    end
                end
            end
            WRITE: begin
                word_idx_d   = word_idx_q + 1'b1;
                word_count_d = word_count_q + 1'b1;
                byte_idx_d   = '0;
`ifdef IMEM_LOADER_CSUM_EN
                csum_d       = csum_q + mem_wdata_q;
`endif
                state_d      = (word_count_d == len_q) ? DONE : RECV;
            end
            default: state_d = IDLE;
        endcase
        byte_ready_d = (state_d == RECV);
        mem_we_d     = (state_d == WRITE);
        busy_d       = (state_d == RECV) || (state_d == WRITE);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            word_count_q <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            shift_q      <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_count_q <= word_count_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign byte_ready   = byte_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cpu_rst_hold = busy_q;
    assign word_count   = word_count_q;
`ifdef IMEM_LOADER_CSUM_EN
    assign csum         = csum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte packing, addressing, start/rst handling.
// Checksum steps are included when IMEM_LOADER_CSUM_EN is defined.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] len_words;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        cpu_rst_hold;
    logic [15:0] word_count;
`ifdef IMEM_LOADER_CSUM_EN
    logic [31:0] csum;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] qa[$];
    logic [31:0] qd[$];
    bit          ready_seen;

    imem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .len_words    (len_words),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .cpu_rst_hold (cpu_rst_hold),
`ifdef IMEM_LOADER_CSUM_EN
        .csum         (csum),
`endif
        .word_count   (word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            qa.push_back(mem_addr);
            qd.push_back(mem_wdata);
        end
        if (byte_ready) ready_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] n);
        len_words = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int n = 0; n < 20 && !ok; n++) begin
            ok = byte_ready;
            tick();
        end
        byte_valid = 1'b0;
        if (!ok) check("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            for (int g = 0; g < gap; g++) tick();
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            ok = done;
            if (!ok) tick();
        end
        if (!ok) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_q(input string tag, input int idx,
                           input logic [31:0] a, input logic [31:0] d);
        if (idx < qa.size()) begin
            check({tag, "_addr"}, qa[idx], a);
            check({tag, "_data"}, qd[idx], d);
        end else begin
            check({tag, "_missing"}, 32'd0, 32'd1);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
        check({tag, "_hold"}, {31'd0, cpu_rst_hold}, 32'd0);
        check({tag, "_wcnt"}, {16'd0, word_count}, 32'd0);
        check({tag, "_addr"}, mem_addr, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        len_words  = '0;
        byte_valid = 1'b0;
        byte_data  = '0;
        tick();
        tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Single word
        pulse_start(16'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        send_word(32'h0000_0013, 0);
        check("t1_we_latency", {31'd0, mem_we}, 32'd1);
        wait_done();
        check("t1_nwrites", qa.size(), 32'd1);
        check_q("t1_w0", 0, 32'h0, 32'h0000_0013);
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_wcnt", {16'd0, word_count}, 32'd1);
        check("t1_busy_low", {31'd0, busy}, 32'd0);
        check("t1_wdata_hold", mem_wdata, 32'h0000_0013);

        // Three words, valid toggling
        qa.delete();
        qd.delete();
        pulse_start(16'd3);
        check("t2_hold_start", {31'd0, cpu_rst_hold}, 32'd1);
        check("t2_done_clr", {31'd0, done}, 32'd0);
        send_word(32'h0050_0093, 1);
        check("t2_hold_mid", {31'd0, cpu_rst_hold}, 32'd1);
        send_word(32'h00A0_0113, 1);
        send_word(32'h0020_81B3, 1);
        wait_done();
        check("t2_nwrites", qa.size(), 32'd3);
        check_q("t2_w0", 0, 32'h0, 32'h0050_0093);
        check_q("t2_w1", 1, 32'h4, 32'h00A0_0113);
        check_q("t2_w2", 2, 32'h8, 32'h0020_81B3);
        check("t2_hold_done", {31'd0, cpu_rst_hold}, 32'd0);
        check("t2_wcnt", {16'd0, word_count}, 32'd3);

        // Zero-length load
        qa.delete();
        qd.delete();
        ready_seen = 1'b0;
        pulse_start(16'd0);
        check("t3_done", {31'd0, done}, 32'd1);
        check("t3_busy", {31'd0, busy}, 32'd0);
        check("t3_wcnt", {16'd0, word_count}, 32'd0);
        tick();
        tick();
        check("t3_no_ready", {31'd0, ready_seen}, 32'd0);
        check("t3_no_write", qa.size(), 32'd0);

        // Start pulse ignored while busy
        pulse_start(16'd2);
        send_byte(8'h01);
        send_byte(8'h02);
        pulse_start(16'd7);
        check("t4_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h03);
        send_byte(8'h04);
        send_word(32'h0807_0605, 0);
        wait_done();
        check("t4_nwrites", qa.size(), 32'd2);
        check_q("t4_w0", 0, 32'h0, 32'h0403_0201);
        check_q("t4_w1", 1, 32'h4, 32'h0807_0605);
        check("t4_wcnt", {16'd0, word_count}, 32'd2);

        // Reset mid-load
        qa.delete();
        qd.delete();
        pulse_start(16'd4);
        send_word(32'hDEAD_BEEF, 0);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        #1;
        check_idle_outputs("t5_rst");
        check("t5_nwrites", qa.size(), 32'd1);
        check_q("t5_w0", 0, 32'h0, 32'hDEAD_BEEF);
        tick();
        rst = 1'b0;
        tick();
        qa.delete();
        qd.delete();
        pulse_start(16'd1);
        send_word(32'hCAFE_F00D, 0);
        wait_done();
        check("t5_nwrites2", qa.size(), 32'd1);
        check_q("t5_w1", 0, 32'h0, 32'hCAFE_F00D);

`ifdef IMEM_LOADER_CSUM_EN
        pulse_start(16'd2);
        check("t6_csum_clr", csum, 32'd0);
        send_word(32'hFFFF_FFFF, 0);
        send_word(32'h0000_0002, 0);
        wait_done();
        check("t6_csum", csum, 32'h0000_0001);
        pulse_start(16'd0);
        check("t6_csum_restart", csum, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
